// File: rtl/timer_if.sv
// Peripheral-bus view of the countdown timer: CPU-side address/data/strobe
// plus the read-data and interrupt lines returned to the bridge.
interface timer_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  modport master (output Addr, WE, DIn, input DOut, IRQ);
  modport slave  (input Addr, WE, DIn, output DOut, IRQ);
endinterface

// File: rtl/timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, one-shot or
// auto-reload countdown, interrupt raised when the count reaches zero.
module timer (
  input  logic    clk,
  input  logic    reset,
  timer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} st_t;

  st_t         st_q, st_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;

  logic       en;
  logic [1:0] mode;
  logic       im;

  assign en   = ctrl_q[0];
  assign mode = ctrl_q[2:1];
  assign im   = ctrl_q[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q     <= IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      pend_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;

    case (st_q)
      IDLE: begin
        if (en) st_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        st_d    = en ? CNT : IDLE;
      end
      CNT: begin
        if (!en) begin
          st_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          pend_d  = 1'b1;
          st_d    = INT;
        end
      end
      INT: begin
        if (mode == 2'b01) begin
          pend_d = 1'b0;
          st_d   = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          st_d      = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase

    // Bus writes are applied last so they override the state machine's
    // EN clear and PEND set/clear on the same edge.
    if (bus.WE) begin
      case (bus.Addr)
        2'd0: begin
          ctrl_d = bus.DIn[3:0];
          pend_d = 1'b0;
        end
        2'd1: begin
          preset_d = bus.DIn;
          pend_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (bus.Addr)
      2'd0:    bus.DOut = {28'd0, ctrl_q};
      2'd1:    bus.DOut = preset_q;
      2'd2:    bus.DOut = count_q;
      default: bus.DOut = 32'd0;
    endcase
  end

  assign bus.IRQ = pend_q & im;

endmodule

// File: tb/tb_timer.sv
// Directed bench for the countdown timer: reset, one-shot, auto-reload,
// masking, disable mid-count and register-map corners.
module tb_timer;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  timer_if bus ();

  timer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = a;
    bus.DIn  = d;
    bus.WE   = 1'b1;
    @(posedge clk);
    #1;
    bus.WE   = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.Addr = a;
    #1;
    chk(tag, bus.DOut, exp);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    bus.Addr = 2'd0;
    bus.WE   = 1'b0;
    bus.DIn  = 32'd0;
    repeat (2) step();
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_irq", {31'd0, bus.IRQ}, 32'd0);
    chk_rd("rst_ctrl", 2'd0, 32'd0);
    chk_rd("rst_preset", 2'd1, 32'd0);
    chk_rd("rst_count", 2'd2, 32'd0);

    // One-shot, PRESET=5, IM=1
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);              // E0
    step();                       // E1 LOAD
    for (int k = 0; k < 5; k++) begin
      step();                     // E2..E6
      chk_rd("os_count", 2'd2, 32'd5 - 32'(k));
      chk("os_irq_low", {31'd0, bus.IRQ}, 32'd0);
    end
    step();                       // E7
    chk("os_irq_e7", {31'd0, bus.IRQ}, 32'd1);
    chk_rd("os_count_e7", 2'd2, 32'd0);
    step();                       // E8
    chk_rd("os_ctrl_e8", 2'd0, 32'h8);
    chk("os_irq_e8", {31'd0, bus.IRQ}, 32'd1);
    step();
    chk("os_irq_hold", {31'd0, bus.IRQ}, 32'd1);
    wr(2'd0, 32'h0);
    chk("os_irq_clr", {31'd0, bus.IRQ}, 32'd0);

    // Auto-reload, PRESET=3: pulses at E5, E10, E15
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);              // E0
    for (int e = 1; e <= 16; e++) begin
      step();
      chk("ar_irq", {31'd0, bus.IRQ}, (e == 5 || e == 10 || e == 15) ? 32'd1 : 32'd0);
      if (e == 7 || e == 12) chk_rd("ar_reload", 2'd2, 32'd3);
      if (e == 9) chk_rd("ar_count_e9", 2'd2, 32'd1);
    end
    wr(2'd0, 32'h0);
    step();
    chk("ar_stop_irq", {31'd0, bus.IRQ}, 32'd0);

    // Masked one-shot, PRESET=2
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);              // E0
    for (int e = 1; e <= 6; e++) begin
      step();
      chk("mask_irq", {31'd0, bus.IRQ}, 32'd0);
    end
    chk_rd("mask_count", 2'd2, 32'd0);
    chk_rd("mask_ctrl", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    chk("mask_irq_after_im", {31'd0, bus.IRQ}, 32'd0);
    step();
    chk("mask_irq_later", {31'd0, bus.IRQ}, 32'd0);

    // Disable mid-count, PRESET=100
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);              // E0
    repeat (42) step();           // E42: COUNT = 60
    chk_rd("dis_count60", 2'd2, 32'd60);
    wr(2'd0, 32'h8);              // final decrement on this edge
    chk_rd("dis_freeze_a", 2'd2, 32'd59);
    repeat (3) step();
    chk_rd("dis_freeze_b", 2'd2, 32'd59);
    chk("dis_irq", {31'd0, bus.IRQ}, 32'd0);
    wr(2'd0, 32'h9);              // re-enable
    step();
    step();
    chk_rd("dis_reload", 2'd2, 32'd100);
    wr(2'd0, 32'h0);
    step();

    // Bus corners: PRESET write during count, writes to offsets 2/3
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h1);              // E0
    step();
    step();                       // E2
    chk_rd("bc_count20", 2'd2, 32'd20);
    wr(2'd1, 32'd7);              // E3
    chk_rd("bc_count19", 2'd2, 32'd19);
    chk_rd("bc_preset7", 2'd1, 32'd7);
    wr(2'd2, 32'h55);             // E4
    wr(2'd3, 32'h1234);           // E5
    chk_rd("bc_count17", 2'd2, 32'd17);
    chk_rd("bc_off3", 2'd3, 32'd0);
    chk_rd("bc_preset_keep", 2'd1, 32'd7);
    chk_rd("bc_ctrl_keep", 2'd0, 32'h1);
    repeat (16) step();           // E21
    chk_rd("bc_count1", 2'd2, 32'd1);
    step();                       // E22
    chk_rd("bc_count0", 2'd2, 32'd0);
    step();                       // E23
    chk_rd("bc_ctrl_done", 2'd0, 32'h0);
    wr(2'd0, 32'hFFFF_FFFF);
    chk_rd("bc_ctrl_f", 2'd0, 32'hF);
    wr(2'd0, 32'h0);
    step();
    step();

    // PRESET = 0 behaves like 1: PEND at E3
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);              // E0
    step();
    step();                       // E2
    chk("p0_irq_e2", {31'd0, bus.IRQ}, 32'd0);
    step();                       // E3
    chk("p0_irq_e3", {31'd0, bus.IRQ}, 32'd1);

    // Asynchronous reset while IRQ is high in auto-reload
    wr(2'd1, 32'd9);              // clears PEND
    wr(2'd0, 32'hB);              // E0
    repeat (11) step();           // E11: INT
    chk("ar9_irq_e11", {31'd0, bus.IRQ}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_irq", {31'd0, bus.IRQ}, 32'd0);
    chk_rd("async_rst_ctrl", 2'd0, 32'd0);
    chk_rd("async_rst_preset", 2'd1, 32'd0);
    chk_rd("async_rst_count", 2'd2, 32'd0);
    step();
    reset = 1'b0;
    repeat (4) step();
    chk("post_rst_irq", {31'd0, bus.IRQ}, 32'd0);
    chk_rd("post_rst_count", 2'd2, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer.md
# timer

Memory-mapped countdown timer that sits on the processor's peripheral bus as a responder, answering the CPU's `PrAddr` / `PrWD` / `PrWe` / `PrRD` transactions through the bridge. It drives one bit of the CPU's `HWInt[7:2]` interrupt vector. Software loads a preset value and enables it. The timer then counts down once per clock and raises an interrupt at zero, either once (one-shot) or periodically (auto-reload).

## Interface
Parameters: none; the register map is fixed.

- `clk`  in  1  system clock; every register updates on its rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-high.
- `Addr`  in  2  word offset within the device, driven from `PrAddr[3:2]` by the bridge.
- `WE`  in  1  write strobe; the bridge qualifies it with device select and `PrWe`.
- `DIn`  in  32  write data (`PrWD`).
- `DOut`  out  32  read data, combinational from `Addr`; goes to the bridge `PrRD` mux.
- `IRQ`  out  1  interrupt request, connected to one `HWInt` bit.

## Operation
Register map (word offsets):
- 0 `CTRL`: read/write, bits [3:0] only; bits [31:4] write-ignored, read 0.
  - [0] `EN`: enable.
  - [2:1] `MODE`: 00 = one-shot, 01 = auto-reload, 10/11 = treated as one-shot.
  - [3] `IM`: interrupt mask enable.
- 1 `PRESET`: read/write, full 32 bits.
- 2 `COUNT`: read-only; writes are ignored.
- 3: reads 0; writes are ignored.

Internal state: `CTRL[3:0]`, `PRESET[31:0]`, `COUNT[31:0]`, `PEND` (1 bit), and a state machine `st` ∈ {IDLE, LOAD, CNT, INT}.

Reset values: all registers 0, `st` = IDLE, `IRQ` = 0, `DOut` = 0 (since `Addr` selects a zero register).

State machine (evaluated each rising edge):
- IDLE: if `EN` = 1, go to LOAD. Otherwise stay; `COUNT` holds.
- LOAD: `COUNT` <= `PRESET`; go to CNT. If `EN` = 0, go to IDLE instead.
- CNT:
  - If `EN` = 0: go to IDLE; `COUNT` holds.
  - Else if `COUNT` > 1: `COUNT` <= `COUNT` − 1.
  - Else (`COUNT` ∈ {0, 1}): `COUNT` <= 0, `PEND` <= 1, go to INT.
- INT:
  - `MODE` = 01: `PEND` <= 0, go to LOAD.
  - Otherwise: `EN` <= 0, go to IDLE; `PEND` stays 1.

Interrupt output:
- `IRQ` = `PEND` & `IM`. It is registered state only, with no combinational path from the bus.
- One-shot: `PEND` stays set until software writes `CTRL` or `PRESET`. Either write clears `PEND` on that edge.
- Auto-reload: `PEND` is high for exactly one cycle per period.

Bus writes:
- A write takes effect on the edge where `WE` = 1; the state machine sees the new value from the next cycle.
- A bus write to `CTRL` on the same edge that INT clears `EN` takes priority: the written `EN` wins. That write also clears `PEND`.
- A `PRESET` write during CNT does not change `COUNT`; the new value applies at the next LOAD.
- Writing `CTRL` with `EN` = 1 while already counting does not restart the count.

## Timing
Take edge E0 as the edge that writes `CTRL.EN` = 1 while in IDLE, with `PRESET` = N ≥ 1:
- E1: `st` = LOAD.
- E2: `COUNT` = N, `st` = CNT.
- E(2+k): `COUNT` = N − k, for k < N.
- E(2+N): `COUNT` = 0, `st` = INT, `PEND` = 1. `IRQ` rises after this edge.
- One-shot: E(3+N) gives `st` = IDLE and `EN` = 0.
- Auto-reload: E(3+N) gives `st` = LOAD and `IRQ` falls; E(4+N) reloads `COUNT` = N. The period is N + 2 cycles.
- `PRESET` = 0 behaves like `PRESET` = 1: `PEND` is set at E3.

Other timing rules:
- `DOut` and `IRQ` have no bus-to-output combinational path within a cycle except `DOut`'s dependence on `Addr`.
- Asserting `reset` mid-count clears all state immediately, independent of `clk`, and forces `IRQ` = 0 immediately.

## Test plan
- **Reset:** assert `reset` mid-count with `IRQ` = 1 → `IRQ`, `CTRL`, `PRESET`, `COUNT` read 0 without a clock edge; `st` = IDLE.
- **One-shot:** write `PRESET` = 5, then `CTRL` = 0x9 → `COUNT` reads 5,4,3,2,1 on consecutive cycles starting 2 cycles after the write; `IRQ` = 1 at E7 and stays high; `CTRL` reads 0x8 after E8; a `CTRL` write of 0 drops `IRQ`.
- **Auto-reload:** `PRESET` = 3, `CTRL` = 0xB → `IRQ` is a single-cycle pulse at E5, E10, E15 (period 5); `COUNT` reloads to 3 after each pulse.
- **Mask:** `CTRL` = 0x1, `PRESET` = 2 → `IRQ` stays 0, `COUNT` reaches 0, `CTRL` reads 0x0 afterward; a later `CTRL` write of 0x8 leaves `IRQ` = 0 because that write clears `PEND`.
- **Disable mid-count:** `PRESET` = 100, enable, write `CTRL` = 0x8 when `COUNT` = 60 → `COUNT` freezes at 59 or 60 per edge ordering, with no `IRQ`; re-enabling reloads 100.
- **Bus corners:** write `PRESET` = 7 during a count of 20 → the current count completes from 20; writes to offsets 2 and 3 change nothing; offset 3 reads 0; `CTRL` write of 0xFFFFFFFF reads back 0xF.
